// File: rtl/mul_seq_8_pkg.sv
// Shared definitions for the sequential 8x8 shift-and-add multiplier:
// state encodings, operand width and iteration limits.
package mul_seq_8_pkg;

  localparam int N_BITS = 8;
  localparam int CNT_W  = 3;

  localparam logic [CNT_W-1:0] LAST_ITER = 3'd7;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/adder_8.sv
// 8-bit ripple-carry adder used as the multiplier's add path.
// Purely combinational; the clk pin exists only for interface compatibility.
module adder_8 (
  input  logic       clk,
  input  logic [7:0] a,
  input  logic [7:0] b,
  input  logic       cin,
  output logic [7:0] s,
  output logic       c
);

  logic [8:0] carry;
  logic       unused_clk;

  assign unused_clk = clk;
  assign carry[0]   = cin;

  for (genvar i = 0; i < 8; i++) begin : g_rca
    assign s[i]       = a[i] ^ b[i] ^ carry[i];
    assign carry[i+1] = (a[i] & b[i]) | (carry[i] & (a[i] ^ b[i]));
  end

  assign c = carry[8];

endmodule

// File: rtl/mul_seq_8.sv
// Sequential 8x8 unsigned shift-and-add multiplier: one multiplier bit per
// cycle through adder_8, 16-bit product with a one-cycle done pulse.
//
// state   | meaning
// IDLE    | waiting for start; last product held on the output
// CALC    | eight add/shift iterations, busy high
// DONE    | one-cycle done pulse, then back to IDLE
module mul_seq_8
  import mul_seq_8_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [N_BITS-1:0]     a,
  input  logic [N_BITS-1:0]     b,
  output logic                  busy,
  output logic                  done,
  output logic [2*N_BITS-1:0]   product
);

  state_t                state, state_nxt;
  logic [N_BITS-1:0]     mcand, mcand_nxt;
  logic [2*N_BITS-1:0]   p, p_nxt;
  logic [CNT_W-1:0]      count, count_nxt;

  logic [N_BITS-1:0]     add_b;
  logic [N_BITS-1:0]     add_s;
  logic                  add_c;

  assign add_b = p[0] ? mcand : '0;

  adder_8 u_adder (
    .clk (clk),
    .a   (p[2*N_BITS-1:N_BITS]),
    .b   (add_b),
    .cin (1'b0),
    .s   (add_s),
    .c   (add_c)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
      mcand <= '0;
      p     <= '0;
      count <= '0;
    end else begin
      state <= state_nxt;
      mcand <= mcand_nxt;
      p     <= p_nxt;
      count <= count_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    mcand_nxt = mcand;
    p_nxt     = p;
    count_nxt = count;
    case (state)
      ST_IDLE: begin
        if (start) begin
          mcand_nxt = a;
          p_nxt     = {{N_BITS{1'b0}}, b};
          count_nxt = '0;
          state_nxt = ST_CALC;
        end
      end
      ST_CALC: begin
        // Carry lands in the top bit, so the 9-bit partial sum is never truncated.
        p_nxt     = {add_c, add_s, p[N_BITS-1:1]};
        count_nxt = count + CNT_W'(1);
        if (count == LAST_ITER) state_nxt = ST_DONE;
      end
      ST_DONE: state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  assign busy    = (state == ST_CALC);
  assign done    = (state == ST_DONE);
  assign product = p;

endmodule

// File: tb/tb_mul_seq_8.sv
// Self-checking bench for mul_seq_8: directed operand vectors, a cycle-level
// reference model built from plain multiplication, and per-cycle compares.
module tb_mul_seq_8;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [7:0]  a = '0;
  logic [7:0]  b = '0;
  logic        busy;
  logic        done;
  logic [15:0] product;

  int vectors = 0;
  int miscompares = 0;
  int done_count = 0;

  // age: edges since the accepted start (0 = never started since reset)
  int          age = 0;
  logic [15:0] pending = '0;
  logic [15:0] exp_product = '0;

  mul_seq_8 dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .a       (a),
    .b       (b),
    .busy    (busy),
    .done    (done),
    .product (product)
  );

  always #5 clk = ~clk;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      age = 0;
      pending = '0;
      exp_product = '0;
    end else if ((age == 0 || age >= 10) && start) begin
      pending = 16'(a) * 16'(b);
      age = 1;
    end else if (age > 0 && age < 10) begin
      age = age + 1;
      if (age == 9) exp_product = pending;
    end
  end

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, req, $time);
    end
  endtask

  always @(negedge clk) begin
    check("busy", 16'(busy), 16'(age >= 1 && age <= 8));
    check("done", 16'(done), 16'(age == 9));
    if (age == 0 || age >= 9) check("product", product, exp_product);
    if (done === 1'b1) done_count++;
  end

  // Runs one multiply; optionally re-pulses start during CALC at cycle inj.
  task automatic run_op(input logic [7:0] ta, input logic [7:0] tb_v,
                        input logic [15:0] expv, input string name, input int inj);
    int cyc;
    int d0;
    @(negedge clk);
    a = ta; b = tb_v; start = 1'b1;
    @(negedge clk);
    start = 1'b0; a = 8'($urandom); b = 8'($urandom);
    d0 = done_count;
    cyc = 1;
    while (done !== 1'b1 && cyc < 20) begin
      @(negedge clk);
      if (inj != 0 && cyc == inj) begin
        start = 1'b1; a = 8'd9; b = 8'd9;
      end else begin
        start = 1'b0;
      end
      cyc++;
    end
    start = 1'b0;
    check({name, "_latency"}, 16'(cyc), 16'd9);
    check({name, "_lit"}, product, expv);
    repeat (12) @(negedge clk);
    check({name, "_ndone"}, 16'(done_count - d0), 16'd1);
    check({name, "_hold"}, product, expv);
  endtask

  initial begin
    int d0;
    repeat (2) @(negedge clk);
    check("rst_product", product, 16'h0000);
    check("rst_busy", 16'(busy), 16'd0);
    #2 rst = 1'b0;

    run_op(8'd13,  8'd11,  16'h008F, "t1_13x11",   0);
    run_op(8'd255, 8'd255, 16'hFE01, "t2_255x255", 0);
    run_op(8'd0,   8'd200, 16'h0000, "t3_0x200",   0);
    run_op(8'd200, 8'd0,   16'h0000, "t3_200x0",   0);
    run_op(8'd1,   8'h80,  16'h0080, "t4_1x80",    0);
    run_op(8'h80,  8'd1,   16'h0080, "t4_80x1",    0);
    run_op(8'd3,   8'd5,   16'd15,   "t5_ignore",  3);

    // Reset during the 4th CALC cycle
    @(negedge clk);
    a = 8'd7; b = 8'd6; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("t6_rst_busy", 16'(busy), 16'd0);
    check("t6_rst_done", 16'(done), 16'd0);
    check("t6_rst_product", product, 16'h0000);
    d0 = done_count;
    @(negedge clk);
    #2 rst = 1'b0;
    repeat (15) @(negedge clk);
    check("t6_no_done", 16'(done_count - d0), 16'd0);
    run_op(8'd7, 8'd6, 16'd42, "t6_after_rst", 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
